// File: rtl/gelato_scoreboard_if.sv
// rtl/gelato_scoreboard_if.sv - scheduler/writeback <-> scoreboard signal bundle
// Purpose: groups the alloc, release and hazard-table signals of the per-warp
//          destination-register scoreboard.
// Signals:
//   alloc_valid/alloc_warp/alloc_reg        scheduler records a destination register
//   release_valid/release_warp/release_reg  writeback retires a register
//   regs                                    dirty table, slot [w][s] at ((w*SIZE+s)*REG_W)+:REG_W
//   full                                    bit w = warp w has no empty slot
//   occupancy                               live-slot count per warp, OCC_W bits each
//   overflow/underflow                      sticky error flags
// Modports: master = scheduler/writeback side, slave = scoreboard.
interface gelato_scoreboard_if #(
    parameter int WARP_NUM        = 4,
    parameter int SCOREBOARD_SIZE = 4,
    parameter int REG_W           = 5,
    parameter int WARP_W          = 2
);
    localparam int OCC_W = $clog2(SCOREBOARD_SIZE) + 1;

    logic                                       alloc_valid;
    logic [WARP_W-1:0]                          alloc_warp;
    logic [REG_W-1:0]                           alloc_reg;
    logic                                       release_valid;
    logic [WARP_W-1:0]                          release_warp;
    logic [REG_W-1:0]                           release_reg;
    logic [WARP_NUM*SCOREBOARD_SIZE*REG_W-1:0]  regs;
    logic [WARP_NUM-1:0]                        full;
    logic [WARP_NUM*OCC_W-1:0]                  occupancy;
    logic                                       overflow;
    logic                                       underflow;

    modport master (
        output alloc_valid, alloc_warp, alloc_reg,
        output release_valid, release_warp, release_reg,
        input  regs, full, occupancy, overflow, underflow
    );

    modport slave (
        input  alloc_valid, alloc_warp, alloc_reg,
        input  release_valid, release_warp, release_reg,
        output regs, full, occupancy, overflow, underflow
    );
endinterface

// File: rtl/gelato_scoreboard.sv
// rtl/gelato_scoreboard.sv - per-warp destination-register scoreboard
// Purpose: records the rd of every issued instruction per warp, frees it on
//          writeback and exports the dirty-register table plus full flags.
// Ports:
//   clk  in  clock
//   rst  in  synchronous reset, active-high (overrides rdy)
//   rdy  in  global enable; low freezes all state
//   sb   gelato_scoreboard_if.slave (alloc, release, regs, full, occupancy,
//        overflow, underflow)
// Option: GELATO_SCOREBOARD_BYPASS_EN - a release in progress is shown on
//         regs/full in the same cycle; registered timing is unchanged.
module gelato_scoreboard #(
    parameter int WARP_NUM        = 4,
    parameter int SCOREBOARD_SIZE = 4,
    parameter int REG_W           = 5,
    parameter int WARP_W          = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    gelato_scoreboard_if.slave    sb
);
    localparam int OCC_W = $clog2(SCOREBOARD_SIZE) + 1;

    logic [REG_W-1:0] slot_q    [WARP_NUM][SCOREBOARD_SIZE];
    logic [REG_W-1:0] slot_rel  [WARP_NUM][SCOREBOARD_SIZE];
    logic [REG_W-1:0] slot_next [WARP_NUM][SCOREBOARD_SIZE];
    logic [REG_W-1:0] disp      [WARP_NUM][SCOREBOARD_SIZE];
    logic [OCC_W-1:0] occ_q     [WARP_NUM];
    logic [OCC_W-1:0] occ_next  [WARP_NUM];
    logic             overflow_q;
    logic             underflow_q;

    logic rel_act;
    logic alloc_act;
    logic rel_hit;
    logic alloc_present;
    logic alloc_done;
    logic underflow_set;
    logic overflow_set;

    // Register 0 means "no destination", so it never touches the table.
    assign rel_act   = sb.release_valid && (sb.release_reg != '0);
    assign alloc_act = sb.alloc_valid   && (sb.alloc_reg   != '0);

    // Release is applied to the pre-cycle table first; the alloc then sees the
    // post-release table so a slot freed this cycle can be reused at once.
    always_comb begin
        rel_hit       = 1'b0;
        alloc_present = 1'b0;
        alloc_done    = 1'b0;
        slot_rel      = slot_q;
        for (int w = 0; w < WARP_NUM; w++) begin
            for (int s = 0; s < SCOREBOARD_SIZE; s++) begin
                if (rel_act && (WARP_W'(w) == sb.release_warp) &&
                    (slot_q[w][s] == sb.release_reg)) begin
                    slot_rel[w][s] = '0;
                    rel_hit        = 1'b1;
                end
            end
        end

        for (int w = 0; w < WARP_NUM; w++) begin
            for (int s = 0; s < SCOREBOARD_SIZE; s++) begin
                if (alloc_act && (WARP_W'(w) == sb.alloc_warp) &&
                    (slot_rel[w][s] == sb.alloc_reg)) begin
                    alloc_present = 1'b1;
                end
            end
        end

        // Lowest-index empty slot wins; a register already dirty is not duplicated.
        slot_next = slot_rel;
        for (int w = 0; w < WARP_NUM; w++) begin
            for (int s = 0; s < SCOREBOARD_SIZE; s++) begin
                if (alloc_act && !alloc_present && !alloc_done &&
                    (WARP_W'(w) == sb.alloc_warp) && (slot_rel[w][s] == '0)) begin
                    slot_next[w][s] = sb.alloc_reg;
                    alloc_done      = 1'b1;
                end
            end
        end

        // Counting the next table keeps occupancy exact by construction.
        for (int w = 0; w < WARP_NUM; w++) begin
            occ_next[w] = '0;
            for (int s = 0; s < SCOREBOARD_SIZE; s++) begin
                if (slot_next[w][s] != '0) begin
                    occ_next[w] = occ_next[w] + OCC_W'(1);
                end
            end
        end
    end

    assign underflow_set = rel_act && !rel_hit;
    assign overflow_set  = alloc_act && !alloc_present && !alloc_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < WARP_NUM; w++) begin
                occ_q[w] <= '0;
                for (int s = 0; s < SCOREBOARD_SIZE; s++) begin
                    slot_q[w][s] <= '0;
                end
            end
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (rdy) begin
            slot_q <= slot_next;
            occ_q  <= occ_next;
            if (overflow_set) begin
                overflow_q <= 1'b1;
            end
            if (underflow_set) begin
                underflow_q <= 1'b1;
            end
        end
    end

`ifdef GELATO_SCOREBOARD_BYPASS_EN
    // Show the in-flight release so the scheduler can issue a dependent
    // instruction one cycle earlier.
    always_comb begin
        for (int w = 0; w < WARP_NUM; w++) begin
            for (int s = 0; s < SCOREBOARD_SIZE; s++) begin
                disp[w][s] = rdy ? slot_rel[w][s] : slot_q[w][s];
            end
        end
    end
`else
    always_comb begin
        for (int w = 0; w < WARP_NUM; w++) begin
            for (int s = 0; s < SCOREBOARD_SIZE; s++) begin
                disp[w][s] = slot_q[w][s];
            end
        end
    end
`endif

    logic [WARP_NUM*SCOREBOARD_SIZE*REG_W-1:0] regs_flat;
    logic [WARP_NUM-1:0]                       full_vec;
    logic [WARP_NUM*OCC_W-1:0]                 occ_flat;

    always_comb begin
        regs_flat = '0;
        full_vec  = '0;
        occ_flat  = '0;
        for (int w = 0; w < WARP_NUM; w++) begin
            full_vec[w] = 1'b1;
            occ_flat[w*OCC_W +: OCC_W] = occ_q[w];
            for (int s = 0; s < SCOREBOARD_SIZE; s++) begin
                regs_flat[(w*SCOREBOARD_SIZE+s)*REG_W +: REG_W] = disp[w][s];
                if (disp[w][s] == '0) begin
                    full_vec[w] = 1'b0;
                end
            end
        end
    end

    assign sb.regs      = regs_flat;
    assign sb.full      = full_vec;
    assign sb.occupancy = occ_flat;
    assign sb.overflow  = overflow_q;
    assign sb.underflow = underflow_q;
endmodule

// File: tb/tb_gelato_scoreboard.sv
// tb/tb_gelato_scoreboard.sv - directed self-checking bench for gelato_scoreboard
module tb_gelato_scoreboard;
    localparam int WARP_NUM = 4;
    localparam int SIZE     = 4;
    localparam int REG_W    = 5;
    localparam int WARP_W   = 2;
    localparam int OCC_W    = $clog2(SIZE) + 1;

    logic clk;
    logic rst;
    logic rdy;
    int   checks;
    int   errors;

    gelato_scoreboard_if #(
        .WARP_NUM(WARP_NUM), .SCOREBOARD_SIZE(SIZE), .REG_W(REG_W), .WARP_W(WARP_W)
    ) sb ();

    gelato_scoreboard #(
        .WARP_NUM(WARP_NUM), .SCOREBOARD_SIZE(SIZE), .REG_W(REG_W), .WARP_W(WARP_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .sb  (sb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [REG_W-1:0] slot_of(input int w, input int s);
        return sb.regs[(w*SIZE+s)*REG_W +: REG_W];
    endfunction

    function automatic logic [OCC_W-1:0] occ_of(input int w);
        return sb.occupancy[w*OCC_W +: OCC_W];
    endfunction

    task automatic idle_inputs();
        sb.alloc_valid   = 1'b0;
        sb.alloc_warp    = '0;
        sb.alloc_reg     = '0;
        sb.release_valid = 1'b0;
        sb.release_warp  = '0;
        sb.release_reg   = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic alloc(input int w, input int r);
        sb.alloc_valid = 1'b1;
        sb.alloc_warp  = WARP_W'(w);
        sb.alloc_reg   = REG_W'(r);
    endtask

    task automatic release_reg(input int w, input int r);
        sb.release_valid = 1'b1;
        sb.release_warp  = WARP_W'(w);
        sb.release_reg   = REG_W'(r);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        rdy = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
        tick();

        check("reset_regs", sb.regs, 0);
        check("reset_full", sb.full, 0);
        check("reset_occ", sb.occupancy, 0);
        check("reset_ovf", sb.overflow, 0);
        check("reset_unf", sb.underflow, 0);

        // Fill warp 1 with 5,6,7,8.
        alloc(1, 5); tick();
        check("first_alloc_latency", slot_of(1, 0), 5);
        alloc(1, 6); tick();
        alloc(1, 7); tick();
        alloc(1, 8); tick();
        check("w1_s1", slot_of(1, 1), 6);
        check("w1_s2", slot_of(1, 2), 7);
        check("w1_s3", slot_of(1, 3), 8);
        check("w1_full", sb.full, 4'b0010);
        check("w1_occ4", occ_of(1), 4);

        // Duplicate alloc into a full warp: no slot, no flag.
        alloc(1, 7); tick();
        check("dup_no_ovf", sb.overflow, 0);
        check("dup_occ", occ_of(1), 4);

        // Release 6 + alloc 9 on full warp: freed slot reused.
        release_reg(1, 6); alloc(1, 9); tick();
        check("reuse_slot", slot_of(1, 1), 9);
        check("reuse_occ", occ_of(1), 4);
        check("reuse_no_ovf", sb.overflow, 0);

        // Same reg alloc + release in one cycle: stays dirty.
        release_reg(1, 5); alloc(1, 5); tick();
        check("same_reg_slot", slot_of(1, 0), 5);
        check("same_reg_occ", occ_of(1), 4);

        // Alloc to a full warp is dropped.
        alloc(1, 10); tick();
        check("ovf_set", sb.overflow, 1);
        check("ovf_slot_kept", slot_of(1, 3), 8);

        // Underflow: warp 2 holds 3, release 3 on warp 0.
        alloc(2, 3); tick();
        release_reg(0, 3); tick();
        check("unf_set", sb.underflow, 1);
        check("unf_w2_kept", slot_of(2, 0), 3);
        check("unf_w2_occ", occ_of(2), 1);

        // Independent release (warp 1) and alloc (warp 2) in one cycle.
        release_reg(1, 7); alloc(2, 11); tick();
        check("indep_rel", slot_of(1, 2), 0);
        check("indep_alloc", slot_of(2, 1), 11);
        check("indep_occ1", occ_of(1), 3);
        check("indep_occ2", occ_of(2), 2);
        check("indep_full", sb.full, 4'b0000);
        alloc(1, 12); tick();
        check("lowest_empty", slot_of(1, 2), 12);

        // Release visibility timing.
        alloc(0, 4); tick();
        check("w0_alloc", slot_of(0, 0), 4);
        release_reg(0, 4);
        #1;
`ifdef GELATO_SCOREBOARD_BYPASS_EN
        check("bypass_same_cycle", slot_of(0, 0), 0);
`else
        check("nobypass_same_cycle", slot_of(0, 0), 4);
`endif
        tick();
        check("release_next_cycle", slot_of(0, 0), 0);
        check("release_occ", occ_of(0), 0);

        // rdy=0 freezes state.
        rdy = 1'b0;
        alloc(3, 10); tick();
        check("frozen_slot", slot_of(3, 0), 0);
        check("frozen_occ", occ_of(3), 0);
        check("frozen_w1", slot_of(1, 2), 12);

        // Reset overrides a pending alloc.
        rdy = 1'b1;
        rst = 1'b1;
        alloc(3, 10); tick();
        rst = 1'b0;
        check("midrst_regs", sb.regs, 0);
        check("midrst_occ", sb.occupancy, 0);
        check("midrst_flags", {sb.overflow, sb.underflow}, 0);
        tick();
        check("midrst_no_reg10", slot_of(3, 0), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
